// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and baud-divisor helper.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        IDLE_LEVEL     = 1'b1;
  localparam logic        START_LEVEL    = 1'b0;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_START = 4'b0010,
    S_DATA  = 4'b0100,
    S_STOP  = 4'b1000
  } uart_state_e;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                    input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Handshake between the transmit-control FSM (master) and the UART transmitter (slave).
interface uart_tx_if;
  import uart_pkg::*;

  logic                      tx_start;
  logic [UART_DATA_BITS-1:0] byte_to_send;
  logic                      busy;
  logic                      end_of_byte;

  modport master (output tx_start, byte_to_send, input busy, end_of_byte);
  modport slave  (input tx_start, byte_to_send, output busy, end_of_byte);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter; tick marks the last clock of each bit period.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned         CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter: one-cycle start strobe in, registered serial line and
// end-of-byte pulse out.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  ctrl,
  output logic      tx
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_e               state, state_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic [2:0]                bit_idx, bit_idx_n;
  logic                      stop_cnt, stop_cnt_n;
  logic                      tx_n, busy_n, eob_n;
  logic                      restart, tick, stop_last, data_last;

  assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));
  assign data_last = (bit_idx == 3'(UART_DATA_BITS - 1));

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      shreg            <= '0;
      bit_idx          <= '0;
      stop_cnt         <= '0;
      tx               <= IDLE_LEVEL;
      ctrl.busy        <= 1'b0;
      ctrl.end_of_byte <= 1'b0;
    end else begin
      state            <= state_n;
      shreg            <= shreg_n;
      bit_idx          <= bit_idx_n;
      stop_cnt         <= stop_cnt_n;
      tx               <= tx_n;
      ctrl.busy        <= busy_n;
      ctrl.end_of_byte <= eob_n;
    end
  end

  always_comb begin
    state_n = S_IDLE;
    case (state)
      S_IDLE:  state_n = ctrl.tx_start ? S_START : S_IDLE;
      S_START: state_n = tick ? S_DATA : S_START;
      S_DATA:  state_n = (tick && data_last) ? S_STOP : S_DATA;
      S_STOP:  state_n = (tick && stop_last) ? S_IDLE : S_STOP;
      default: state_n = S_IDLE;
    endcase
  end

  // tx is the registered next level, so each branch loads the level for the
  // cycle after the edge: shreg[1] is the bit that becomes bit 0 after the shift.
  always_comb begin
    tx_n       = IDLE_LEVEL;
    busy_n     = 1'b1;
    eob_n      = 1'b0;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    restart    = 1'b0;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (ctrl.tx_start) begin
          shreg_n    = ctrl.byte_to_send;
          bit_idx_n  = '0;
          stop_cnt_n = '0;
          restart    = 1'b1;
          tx_n       = START_LEVEL;
          busy_n     = 1'b1;
        end
      end
      S_START: begin
        tx_n = START_LEVEL;
        if (tick) begin
          tx_n      = shreg[0];
          bit_idx_n = '0;
        end
      end
      S_DATA: begin
        tx_n = shreg[0];
        if (tick) begin
          if (data_last) begin
            tx_n = IDLE_LEVEL;
          end else begin
            shreg_n   = shreg >> 1;
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shreg[1];
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_last) begin
            eob_n  = 1'b1;
            busy_n = 1'b0;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        busy_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three configurations against a frame-level line model.
module tb_uart_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_if if_a ();
  uart_tx_if if_b ();
  uart_tx_if if_c ();
  logic tx_a, tx_b, tx_c;

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .ctrl(if_a), .tx(tx_a));
  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .ctrl(if_b), .tx(tx_b));
  uart_tx #(.CLK_FREQ(100_000_000), .BAUD_RATE(115200), .STOP_BITS(1)) dut_c (
    .clk(clk), .reset(reset), .ctrl(if_c), .tx(tx_c));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input int w, input logic st, input logic [7:0] d);
    case (w)
      0: begin if_a.tx_start = st; if_a.byte_to_send = d; end
      1: begin if_b.tx_start = st; if_b.byte_to_send = d; end
      2: begin if_c.tx_start = st; if_c.byte_to_send = d; end
      default: ;
    endcase
  endtask

  // {tx, busy, end_of_byte}
  function automatic logic [2:0] sample(input int w);
    case (w)
      0: return {tx_a, if_a.busy, if_a.end_of_byte};
      1: return {tx_b, if_b.busy, if_b.end_of_byte};
      2: return {tx_c, if_c.busy, if_c.end_of_byte};
      default: return 3'b000;
    endcase
  endfunction

  // Line level at cycle c of a frame: start bit, 8 data bits LSB first, then stop bits.
  function automatic logic exp_level(input logic [7:0] b, input int n, input int c);
    int k;
    k = c / n;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Called at the negedge after tx_start was raised for byte b.
  task automatic run_frame(input int w, input int n, input int s, input logic [7:0] b,
                           input string tag, input int inj_at, input logic [7:0] inj_b,
                           input bit chain, input logic [7:0] next_b);
    int len;
    int mism, eob_seen, busy_cyc;
    logic [7:0] dec;
    logic [2:0] o;
    len = (9 + s) * n;
    mism = 0; eob_seen = 0; busy_cyc = 0; dec = '0;
    @(negedge clk);
    drive(w, 1'b0, b);
    for (int c = 0; c < len; c++) begin
      o = sample(w);
      if (o[2] !== exp_level(b, n, c)) mism++;
      if (o[1] === 1'b1) busy_cyc++;
      if (o[0] === 1'b1) eob_seen++;
      if (c / n >= 1 && c / n <= 8 && c % n == n / 2) dec[c/n-1] = o[2];
      if (inj_at >= 0 && c == inj_at) drive(w, 1'b1, inj_b);
      else if (inj_at >= 0 && c == inj_at + 1) drive(w, 1'b0, inj_b);
      @(negedge clk);
    end
    check({tag, " decoded byte"}, 32'(dec), 32'(b));
    check({tag, " line mismatches"}, mism, 0);
    check({tag, " busy cycles"}, busy_cyc, len);
    check({tag, " early eob"}, eob_seen, 0);
    o = sample(w);
    check({tag, " eob at end"}, 32'(o[0]), 1);
    check({tag, " busy at end"}, 32'(o[1]), 0);
    check({tag, " tx at end"}, 32'(o[2]), 1);
    if (chain) begin
      drive(w, 1'b1, next_b);
    end else begin
      @(negedge clk);
      o = sample(w);
      check({tag, " eob one cycle"}, 32'(o[0]), 0);
    end
  endtask

  task automatic idle(input int w, input int cycles, input string tag);
    int bad;
    logic [2:0] o;
    bad = 0;
    repeat (cycles) begin
      o = sample(w);
      if (o !== 3'b100) bad++;
      @(negedge clk);
    end
    check({tag, " idle violations"}, bad, 0);
  endtask

  initial begin
    logic [7:0] rb, nb;
    logic [2:0] o;
    bit ch;
    int inj;

    reset = 1'b1;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 8'h00);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      o = sample(w);
      check($sformatf("reset state dut%0d", w), 32'(o), 32'(3'b100));
    end
    reset = 1'b1;
    @(negedge clk);
    idle(0, 5, "post reset");

    drive(0, 1'b1, 8'hA5);
    run_frame(0, 10, 1, 8'hA5, "a5", -1, 8'h00, 1'b0, 8'h00);

    drive(0, 1'b1, 8'h0D);
    run_frame(0, 10, 1, 8'h0D, "b2b 0d", -1, 8'h00, 1'b1, 8'h0A);
    run_frame(0, 10, 1, 8'h0A, "b2b 0a", -1, 8'h00, 1'b0, 8'h00);

    drive(0, 1'b1, 8'h20);
    run_frame(0, 10, 1, 8'h20, "mid start", 30, 8'hFF, 1'b0, 8'h00);
    idle(0, 30, "mid start");

    // Asynchronous reset in the middle of a 0x55 frame (data bit 3, line low).
    drive(0, 1'b1, 8'h55);
    @(negedge clk);
    drive(0, 1'b0, 8'h55);
    repeat (44) @(negedge clk);
    #1;
    o = sample(0);
    check("rst pre tx", 32'(o[2]), 0);
    reset = 1'b0;
    #1;
    o = sample(0);
    check("rst async tx", 32'(o[2]), 1);
    check("rst async busy", 32'(o[1]), 0);
    check("rst async eob", 32'(o[0]), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    idle(0, 120, "after rst");
    drive(0, 1'b1, 8'h31);
    run_frame(0, 10, 1, 8'h31, "31", -1, 8'h00, 1'b0, 8'h00);

    drive(1, 1'b1, 8'h00);
    run_frame(1, 10, 2, 8'h00, "stop2 00", -1, 8'h00, 1'b0, 8'h00);

    rb = 8'($urandom);
    drive(0, 1'b1, rb);
    for (int i = 0; i < 8; i++) begin
      nb  = 8'($urandom);
      ch  = (i < 7) && ($urandom_range(0, 1) == 1);
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 95)) : -1;
      run_frame(0, 10, 1, rb, $sformatf("rnd%0d", i), inj, 8'($urandom), ch, nb);
      if (!ch && i < 7) begin
        idle(0, int'($urandom_range(1, 5)), $sformatf("rnd%0d", i));
        drive(0, 1'b1, nb);
      end
      rb = nb;
    end

    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      drive(1, 1'b1, rb);
      run_frame(1, 10, 2, rb, $sformatf("rnd stop2 %0d", i), 40, 8'($urandom), 1'b0, 8'h00);
    end

    drive(2, 1'b1, 8'h41);
    run_frame(2, 868, 1, 8'h41, "default 41", -1, 8'h00, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART serial transmitter, directly downstream of the main transmit-control FSM.
- Accepts a one-cycle `tx_start` strobe plus a byte, serializes it LSB-first on `tx`, then returns a one-cycle `end_of_byte` pulse the FSM uses to advance.
- Owns the baud timing; the FSM never sees bit-level timing.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate.
- STOP_BITS, 1, number of stop bits; legal values are 1 and 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_start  in  1  one-cycle request; sampled only in S_IDLE.
- byte_to_send  in  8  payload; captured on the cycle `tx_start` is accepted.
- tx  out  1  serial line; idle high.
- busy  out  1  high from acceptance through the last stop bit.
- end_of_byte  out  1  one-cycle pulse marking frame completion.

Behaviour:
- Derived constant: CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, integer division (868 at defaults).
  - Elaboration error if CLKS_PER_BIT < 2 or STOP_BITS is not 1 or 2.
- Baud counter width is $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0.
- Reset values: tx=1, busy=0, end_of_byte=0, state=S_IDLE, shift register=0, bit index=0, baud counter=0, stop counter=0.
- Reset is asynchronous: asserting it mid-frame forces tx=1 immediately. No pulse is emitted and any partial frame is discarded.
- All outputs are registered.
- State machine is one-hot with four states:
  - S_IDLE: tx=1, busy=0. On tx_start=1, latch byte_to_send into the shift register, clear counters, go to S_START. busy and tx=0 take effect at the next edge, so latency from strobe to start-bit edge is 1 cycle.
  - S_START: tx=0 for CLKS_PER_BIT cycles, then go to S_DATA with bit index 0.
  - S_DATA: tx = shift register bit 0. Each CLKS_PER_BIT cycles, shift right and increment the 3-bit bit index. After bit index 7 completes, go to S_STOP.
  - S_STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, register end_of_byte=1 and busy=0 and go to S_IDLE.
- end_of_byte is high for exactly one cycle, coincident with the first S_IDLE cycle.
- Frame length, from the first start-bit cycle to the end_of_byte assertion edge, is exactly (9+STOP_BITS)*CLKS_PER_BIT cycles.
- tx_start while busy=1 (any non-idle state) is ignored. It is not queued and does not corrupt the shift register; a change in byte_to_send mid-frame has no effect.
- tx_start on the cycle end_of_byte is high is accepted, because the state is S_IDLE. This gives back-to-back frames with one idle-high cycle between the stop bit and the next start bit.
- tx_start held high continuously starts a new frame each time S_IDLE is reached. Legal, but the upstream FSM never does this.
- Illegal or unreachable state encoding: recover to S_IDLE with tx=1 on the next edge.
- No glitch on tx: it is driven from a flop only.

Decomposition:
- Shared package uart_pkg holds:
  - the one-hot state localparams S_IDLE, S_START, S_DATA, S_STOP (4 bits);
  - UART_DATA_BITS=8;
  - the line-level constants IDLE_LEVEL=1, START_LEVEL=0;
  - a function computing CLKS_PER_BIT from CLK_FREQ and BAUD_RATE, for reuse by a future uart_rx.
- One sub-module, uart_baud_tick:
  - counter with synchronous restart input and a `tick` output pulsing on the count CLKS_PER_BIT-1;
  - uart_tx restarts it on frame acceptance.

Test Plan:
(Bench parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000, giving CLKS_PER_BIT=10.)
- Reset, then tx_start with byte 0xA5 → tx low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles. end_of_byte pulses once, 100 cycles after the start-bit edge; busy is high for exactly those 100 cycles.
- Byte 0x0D, then tx_start on the same cycle end_of_byte is high with 0x0A → second start bit begins exactly 1 cycle after the first stop bit ends; decoded bytes are 0x0D, 0x0A.
- Mid-frame tx_start with byte 0xFF during transmission of 0x20 → decoded byte is 0x20, only one end_of_byte pulse, no second frame.
- Reset asserted at cycle 45 of a 0x55 frame → tx=1 asynchronously (before the next edge), busy=0, no end_of_byte. A subsequent tx_start with 0x31 transmits a clean frame.
- STOP_BITS=2, byte 0x00 → tx low 90 cycles, high 20 cycles; end_of_byte at cycle 110.
- Defaults CLK_FREQ=100_000_000, BAUD_RATE=115200, byte 0x41 → each bit lasts 868 cycles; frame is 8680 cycles.
